// File: rtl/seg7_pkg.sv
// Shared constants and types for the PWM-gated 7-segment monitor.
// Segment patterns are a..g on bits 0..6; dp sits on bit 7 of the bus.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {CAP_NONE, CAP_HELD, CAP_CONFLICT} cap_state_t;

  function automatic int win_len(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

endpackage

// File: rtl/seg7_pwm_monitor_if.sv
// Observed segment bus plus the recovered display readback.
interface seg7_pwm_monitor_if #(parameter int ON_W = 4);

  logic [7:0]      seg_in;
  logic [3:0]      bcd_out;
  logic            bcd_valid;
  logic            blank;
  logic            pattern_err;
  logic [2:0]      brightness_est;
  logic [ON_W-1:0] on_count;
  logic            window_done;

  modport master (output seg_in,
                  input  bcd_out, bcd_valid, blank, pattern_err,
                         brightness_est, on_count, window_done);

  modport slave  (input  seg_in,
                  output bcd_out, bcd_valid, blank, pattern_err,
                         brightness_est, on_count, window_done);

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD lookup; hit=0 for unknown patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] digit,
  output logic       hit
);

  always_comb begin
    digit = '0;
    hit   = 1'b1;
    case (pat)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pwm_monitor.sv
// Recovers digit and brightness from a PWM-gated 7-segment bus, one PWM
// period per window, with blank / error / stability flags.
module seg7_pwm_monitor
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ       = 125_000_000,
  parameter int PWM_FREQ       = 1000,
  parameter int STABLE_WINDOWS = 2
) (
  input  logic             clk,
  input  logic             reset,
  seg7_pwm_monitor_if.slave bus
);

  localparam int WIN_LEN = win_len(CLK_FREQ, PWM_FREQ);
  localparam int ON_W    = $clog2(WIN_LEN + 1);
  localparam int CNT_W   = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIN_LEN - 1);
  localparam logic [3:0]       STAB_MAX = 4'(STABLE_WINDOWS);

  // ceil(k*WIN_LEN/8): on_count >= T_k  <=>  floor(on_count*8/WIN_LEN) >= k
  function automatic int thr(input int k);
    return (k * WIN_LEN + 7) / 8;
  endfunction

  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [ON_W-1:0]  acc_q, acc_d, acc_fin;
  cap_state_t       cap_q, cap_d, cap_fin;
  logic [6:0]       pat_q, pat_d, pat_fin;
  logic [3:0]       stab_q, stab_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             valid_q, valid_d, blank_q, blank_d, err_q, err_d, done_q, done_d;
  logic [2:0]       bri_q, bri_d, bri;
  logic [ON_W-1:0]  on_q, on_d;
  logic [6:0]       seg;
  logic             active, last;
  logic [3:0]       dec_digit;
  logic             dec_hit;

  seg7_pattern_decode u_dec (.pat(pat_fin), .digit(dec_digit), .hit(dec_hit));

  always_comb begin
    seg       = bus.seg_in[SEG_G:SEG_A];
    active    = |seg;
    last      = (win_cnt_q == LAST);
    win_cnt_d = last ? '0 : win_cnt_q + CNT_W'(1);
    acc_fin   = acc_q + ON_W'(active);

    // capture FSM: this cycle's sample folded into the held state
    cap_fin = cap_q;
    pat_fin = pat_q;
    if (active) begin
      case (cap_q)
        CAP_NONE: begin cap_fin = CAP_HELD; pat_fin = seg; end
        CAP_HELD: if (seg != pat_q) cap_fin = CAP_CONFLICT;
        default:  ;
      endcase
    end

    bri = '0;
    for (int k = 1; k < 8; k++)
      if (int'(acc_fin) >= thr(k)) bri = bri + 3'd1;

    acc_d   = acc_fin;
    cap_d   = cap_fin;
    pat_d   = pat_fin;
    stab_d  = stab_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    blank_d = blank_q;
    err_d   = err_q;
    bri_d   = bri_q;
    on_d    = on_q;
    done_d  = 1'b0;

    if (last) begin
      acc_d   = '0;
      cap_d   = CAP_NONE;
      pat_d   = '0;
      done_d  = 1'b1;
      on_d    = acc_fin;
      bri_d   = bri;
      blank_d = (cap_fin == CAP_NONE);
      err_d   = 1'b0;
      stab_d  = '0;
      if (cap_fin == CAP_CONFLICT || (cap_fin == CAP_HELD && !dec_hit)) begin
        err_d = 1'b1;
      end else if (cap_fin == CAP_HELD) begin
        bcd_d = dec_digit;
        if (dec_digit == bcd_q && stab_q != '0)
          stab_d = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 4'd1;
        else
          stab_d = 4'd1;
      end
      valid_d = (stab_d >= STAB_MAX) && (stab_d != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      cap_q     <= CAP_NONE;
      pat_q     <= '0;
      stab_q    <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b0;
      err_q     <= 1'b0;
      bri_q     <= '0;
      on_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      cap_q     <= cap_d;
      pat_q     <= pat_d;
      stab_q    <= stab_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      bri_q     <= bri_d;
      on_q      <= on_d;
      done_q    <= done_d;
    end
  end

  assign bus.bcd_out        = bcd_q;
  assign bus.bcd_valid      = valid_q;
  assign bus.blank          = blank_q;
  assign bus.pattern_err    = err_q;
  assign bus.brightness_est = bri_q;
  assign bus.on_count       = on_q;
  assign bus.window_done    = done_q;

endmodule

// File: tb/tb_seg7_pwm_monitor.sv
// Randomised + directed bench for seg7_pwm_monitor against a per-window
// reference model (WIN_LEN=8, STABLE_WINDOWS=2).
module tb_seg7_pwm_monitor;

  localparam int WIN  = 8;
  localparam int STAB = 2;

  typedef logic [7:0] win_t [WIN];

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg7_pwm_monitor_if #(.ON_W(4)) bus();

  seg7_pwm_monitor #(.CLK_FREQ(8000), .PWM_FREQ(1000), .STABLE_WINDOWS(STAB)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // model state: displayed digit, consecutive-valid count, last valid digit
  int m_bcd = 0, m_stab = 0, m_last = -1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bcd = 0; m_stab = 0; m_last = -1;
  endtask

  task automatic run_window(input win_t p);
    int on, npat, d, b, wd_bad;
    logic [6:0] first;
    bit conflict, blank, err, valid;
    on = 0; npat = 0; first = '0; conflict = 0; wd_bad = 0;
    for (int i = 0; i < WIN; i++) begin
      bus.seg_in = p[i];
      @(negedge clk);
      if (i < WIN - 1 && bus.window_done) wd_bad++;
      if (p[i][6:0] != 7'd0) begin
        on++;
        if (npat == 0) begin first = p[i][6:0]; npat = 1; end
        else if (p[i][6:0] != first) conflict = 1;
      end
    end
    d = -1;
    for (int j = 0; j < 10; j++) if (tbl[j] == first) d = j;
    blank = (npat == 0);
    err   = !blank && (conflict || d < 0);
    if (blank || err) begin
      m_stab = 0;
    end else begin
      m_stab = (d == m_last) ? ((m_stab + 1 > STAB) ? STAB : m_stab + 1) : 1;
      m_last = d;
      m_bcd  = d;
    end
    valid = (m_stab >= STAB);
    b = on * 8 / WIN;
    if (b > 7) b = 7;
    chk("wd_early",    wd_bad, 0);
    chk("window_done", int'(bus.window_done), 1);
    chk("on_count",    int'(bus.on_count), on);
    chk("brightness",  int'(bus.brightness_est), b);
    chk("blank",       int'(bus.blank), int'(blank));
    chk("pattern_err", int'(bus.pattern_err), int'(err));
    chk("bcd_out",     int'(bus.bcd_out), m_bcd);
    chk("bcd_valid",   int'(bus.bcd_valid), int'(valid));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bcd"},   int'(bus.bcd_out), 0);
    chk({tag, "_valid"}, int'(bus.bcd_valid), 0);
    chk({tag, "_blank"}, int'(bus.blank), 0);
    chk({tag, "_err"},   int'(bus.pattern_err), 0);
    chk({tag, "_bri"},   int'(bus.brightness_est), 0);
    chk({tag, "_on"},    int'(bus.on_count), 0);
    chk({tag, "_wd"},    int'(bus.window_done), 0);
  endtask

  function automatic win_t fill(input logic [7:0] v);
    win_t w;
    for (int i = 0; i < WIN; i++) w[i] = v;
    return w;
  endfunction

  function automatic win_t pwm(input logic [7:0] v, input int duty);
    win_t w;
    for (int i = 0; i < WIN; i++) w[i] = (i < duty) ? v : 8'h00;
    return w;
  endfunction

  initial begin
    win_t w;
    int mode, dg;
    bus.seg_in = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    model_reset();
    reset = 1'b0;

    // directed sequence
    run_window(fill(8'h4F));
    run_window(fill(8'h4F));
    run_window(pwm(8'h66, 3));
    run_window(pwm(8'h66, 3));
    run_window(fill(8'h00));
    for (int i = 0; i < WIN; i++) w[i] = (i < 4) ? 8'h06 : 8'h5B;
    run_window(w);
    run_window(fill(8'h5B));
    run_window(fill(8'h5B));
    run_window(fill(8'h49));
    run_window(fill(8'hBF));
    run_window(fill(8'hBF));

    // reset at window cycle 5 with non-zero outputs present
    for (int i = 0; i < 5; i++) begin
      bus.seg_in = 8'h7F;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    run_window(fill(8'h07));

    // randomised windows
    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 5);
      dg   = $urandom_range(0, 9);
      case (mode)
        0: w = fill({1'($urandom_range(0, 1)), tbl[dg]});
        1: w = pwm({1'($urandom_range(0, 1)), tbl[dg]}, $urandom_range(0, WIN));
        2: w = fill({1'($urandom_range(0, 1)), 7'h00});
        3: for (int i = 0; i < WIN; i++)
             w[i] = {1'b0, tbl[(i < 4) ? dg : (dg + 1) % 10]};
        4: for (int i = 0; i < WIN; i++) w[i] = 8'($urandom);
        default: w = fill({1'b0, tbl[(m_bcd >= 0 && m_bcd < 10) ? m_bcd : 0]});
      endcase
      run_window(w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_pwm_monitor.md
Name: seg7_pwm_monitor

Overview:
- Observes the PWM-gated 7-segment bus that drives the traffic-light display and recovers what the display shows: the BCD digit and the brightness level (0-7).
- Measures the on-time over fixed windows of one PWM period and decodes the captured segment pattern.
- Flags blank displays, unrecognised patterns and mid-window pattern changes.
- Sits beside the display driver as an on-chip checker and debug readback path.

Parameters:
- CLK_FREQ, 125_000_000, input clock frequency in Hz.
- PWM_FREQ, 1000, PWM frequency in Hz. The window length is WIN_LEN = CLK_FREQ/PWM_FREQ cycles, and must be at least 8.
- STABLE_WINDOWS, 2, number of consecutive identical windows (1..15) required before bcd_valid asserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- seg_in  in  8  observed segments, active-high. Bits 0..6 are segments a..g; bit 7 is dp, which is ignored for decoding.
- bcd_out  out  4  decoded digit (0-9).
- bcd_valid  out  1  digit has been stable for STABLE_WINDOWS windows.
- blank  out  1  the last window had no active segment at any cycle.
- pattern_err  out  1  the last window's pattern was non-decodable, or the pattern changed within the window.
- brightness_est  out  3  brightness estimate from the last window.
- on_count  out  $clog2(WIN_LEN+1)  raw count of cycles in the last window with seg_in[6:0] != 0.
- window_done  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset: every output is 0; all counters and capture state are cleared.
- Window counter:
  - Free-running, 0..WIN_LEN-1, starting at 0 on the first cycle after reset deasserts.
  - It wraps to 0 after WIN_LEN-1; the cycle with count WIN_LEN-1 is the last sample of the window.
- Per-cycle sampling (a cycle is "active" when seg_in[6:0] != 0):
  - Active cycle: the on accumulator increments.
  - Capture state CAP_NONE: latch seg_in[6:0] and go to CAP_HELD.
  - CAP_HELD, sample differs from the latched pattern: go to CAP_CONFLICT.
  - Inactive cycles never change the capture state.
- Window end (counter = WIN_LEN-1): the last sample is included. On the next cycle, all outputs register together, window_done pulses, and the accumulator and capture state clear. There is no gap between windows.
- Output update:
  - on_count = total active cycles in the window.
  - brightness_est = min(7, floor(on_count*8/WIN_LEN)). Implement with elaborated threshold constants T_k = ceil(k*WIN_LEN/8), k = 1..7; no divider.
  - CAP_NONE: blank=1, pattern_err=0, bcd_out holds its previous value, bcd_valid=0.
  - CAP_CONFLICT: pattern_err=1, blank=0, bcd_valid=0.
  - CAP_HELD: the pattern is looked up in the decode table.
    - Pattern is in the table: pattern_err=0, bcd_out = digit.
    - Pattern is not in the table: pattern_err=1.
- Decode table (a..g on bits 0..6): 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Stability counter:
  - Increments, saturating at STABLE_WINDOWS, on each window that decodes validly to the same digit as the previous valid window.
  - Set to 1 on a valid window with a new digit; cleared on a blank, err or conflict window.
  - bcd_valid = (stability counter >= STABLE_WINDOWS), evaluated on the same update cycle.
- Reset mid-window: all state clears immediately; no window_done is produced for the partial window.

Decomposition:
- Package seg7_pkg holds:
  - the SEG_0..SEG_9 pattern constants and segment bit-index constants;
  - typedef enum cap_state_t {CAP_NONE, CAP_HELD, CAP_CONFLICT};
  - a function win_len(CLK_FREQ, PWM_FREQ).
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern in, 4-bit digit plus hit flag out. It shares the pattern constants with the encoder side.
- The top level holds the window counter, the accumulator, the capture FSM, the threshold compare and the stability counter.

Test Plan (CLK_FREQ=8000, PWM_FREQ=1000, so WIN_LEN=8; STABLE_WINDOWS=2):
- Static drive, no PWM: seg_in=8'h4F for two windows.
  - Window 1: window_done, on_count=8, brightness_est=7, bcd_out=3, bcd_valid=0.
  - Window 2: bcd_valid=1.
- PWM duty 3/8: seg_in=8'h66 for 3 cycles, then 0 for 5, repeated.
  - Expect on_count=3, brightness_est=3, bcd_out=4, with bcd_valid from window 2.
- seg_in=0 for a full window.
  - Expect blank=1, bcd_valid=0, brightness_est=0, bcd_out unchanged.
- Conflict: 8'h06 for cycles 0-3, then 8'h5B for cycles 4-7.
  - Expect pattern_err=1, on_count=8, bcd_valid=0.
  - A following clean 8'h5B window gives bcd_out=2, bcd_valid=0; bcd_valid=1 one window later.
- Illegal pattern and dp handling:
  - seg_in=8'h49 gives pattern_err=1.
  - seg_in=8'hBF (dp set) decodes as 0 with no error.
- Reset asserted at window cycle 5: all outputs go to 0 asynchronously.
  - After release, the first window_done occurs exactly 8 cycles later.
